rs_alu_dispatch: RTL and testbench

//  In-order issue stage feeding the 3-slot ALU reservation station. Buffers decoded ops in a FIFO,

---
 rtl/rs_alu_dispatch_pkg.sv | 98 +++++++++
 rtl/rs_alu_dispatch_fifo.sv | 62 ++++++
 rtl/rs_alu_dispatch.sv | 180 ++++++++++++++++++
 tb/tb_rs_alu_dispatch.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_alu_dispatch_pkg.sv
// Shared widths, tag constants, payload structs and small helper functions
// for the ALU reservation-station dispatch stage.
package rs_alu_dispatch_pkg;

    localparam int ALU_CNT    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int REGADDR_W  = 5;
    localparam int SINST_W    = 6;

    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [ADDR_W-1:0]    addr_t;
    typedef logic [REGADDR_W-1:0] regaddr_t;
    typedef logic [SINST_W-1:0]   sinst_t;

    // Tag value meaning "operand value is present, nothing to wait for".
    localparam tag_t UNLOCKED = '0;
    localparam tag_t TAG_MAX  = '1;

    // Internal ALU op encodings carried on the op payload.
    typedef enum logic [SINST_W-1:0] {
        OP_ADD = 6'd0,
        OP_SUB = 6'd1,
        OP_AND = 6'd2,
        OP_OR  = 6'd3,
        OP_XOR = 6'd4,
        OP_SLT = 6'd5,
        OP_SLL = 6'd6,
        OP_SRL = 6'd7
    } alu_op_e;

    // Decoded op as buffered in the dispatch FIFO.
    typedef struct packed {
        addr_t    pc;
        sinst_t   op;
        regaddr_t rs1;
        regaddr_t rs2;
        regaddr_t rd;
    } dec_op_t;

    // One resolved source operand.
    typedef struct packed {
        tag_t  tag;
        word_t data;
    } operand_t;

    // Payload presented to one reservation-station slot.
    typedef struct packed {
        addr_t    pc;
        sinst_t   op;
        tag_t     tagx;
        tag_t     tagy;
        tag_t     tagw;
        word_t    datax;
        word_t    datay;
        regaddr_t addrw;
    } slot_t;

    // Register 0 is hard-wired ready; otherwise take the RF value, or catch
    // the producing result on the CDB this very cycle, or wait on the tag.
    function automatic operand_t resolve_operand(regaddr_t idx, tag_t rf_tag, word_t rf_data,
                                                 logic cdb_en, tag_t cdb_tag, word_t cdb_data);
        operand_t r;
        r.tag  = UNLOCKED;
        r.data = '0;
        if (idx != '0) begin
            if (rf_tag == UNLOCKED)
                r.data = rf_data;
            else if (cdb_en && (cdb_tag == rf_tag))
                r.data = cdb_data;
            else
                r.tag = rf_tag;
        end
        return r;
    endfunction

    // Rename tags cycle 1..TAG_MAX; 0 is reserved for UNLOCKED.
    function automatic tag_t next_tag(tag_t t);
        return (t == TAG_MAX) ? tag_t'(1) : t + tag_t'(1);
    endfunction

    // One-hot grant of the lowest set bit of the free mask.
    function automatic logic [ALU_CNT-1:0] pick_lowest(logic [ALU_CNT-1:0] free);
        logic [ALU_CNT-1:0] g;
        g = '0;
        for (int k = ALU_CNT - 1; k >= 0; k--) begin
            if (free[k]) begin
                g    = '0;
                g[k] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rs_alu_dispatch_fifo.sv
// Parameterised synchronous FIFO with count-based full/empty and a
// synchronous flush. Push while full is accepted only alongside a pop.
module dispatch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    // NOTE: the array is deliberately not reset; entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rs_alu_dispatch.sv
// In-order issue stage: buffers decoded ops, resolves operands from the RF
// with same-cycle CDB bypass, renames rd and drives one slot per cycle.
module rs_alu_dispatch
    import rs_alu_dispatch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    in_pc,
    input  logic [SINST_W-1:0]   in_op,
    input  logic [REGADDR_W-1:0] in_rs1,
    input  logic [REGADDR_W-1:0] in_rs2,
    input  logic [REGADDR_W-1:0] in_rd,
    output logic [REGADDR_W-1:0] rf_rx_addr,
    output logic [REGADDR_W-1:0] rf_ry_addr,
    input  logic [TAG_W-1:0]     rf_tagx,
    input  logic [TAG_W-1:0]     rf_tagy,
    input  logic [WORD_W-1:0]    rf_datax,
    input  logic [WORD_W-1:0]    rf_datay,
    output logic                 rf_lock_en,
    output logic [REGADDR_W-1:0] rf_lock_addr,
    output logic [TAG_W-1:0]     rf_lock_tag,
    input  logic                 cdb_en,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [WORD_W-1:0]    cdb_data,
    input  logic                 alu0_next_busy,
    input  logic                 alu1_next_busy,
    input  logic                 alu2_next_busy,
    output logic                 en0,
    output logic                 en1,
    output logic                 en2,
    output logic [ADDR_W-1:0]    pc0,
    output logic [ADDR_W-1:0]    pc1,
    output logic [ADDR_W-1:0]    pc2,
    output logic [SINST_W-1:0]   op0,
    output logic [SINST_W-1:0]   op1,
    output logic [SINST_W-1:0]   op2,
    output logic [TAG_W-1:0]     tagx0,
    output logic [TAG_W-1:0]     tagx1,
    output logic [TAG_W-1:0]     tagx2,
    output logic [TAG_W-1:0]     tagy0,
    output logic [TAG_W-1:0]     tagy1,
    output logic [TAG_W-1:0]     tagy2,
    output logic [TAG_W-1:0]     tagw0,
    output logic [TAG_W-1:0]     tagw1,
    output logic [TAG_W-1:0]     tagw2,
    output logic [WORD_W-1:0]    datax0,
    output logic [WORD_W-1:0]    datax1,
    output logic [WORD_W-1:0]    datax2,
    output logic [WORD_W-1:0]    datay0,
    output logic [WORD_W-1:0]    datay1,
    output logic [WORD_W-1:0]    datay2,
    output logic [REGADDR_W-1:0] addrw0,
    output logic [REGADDR_W-1:0] addrw1,
    output logic [REGADDR_W-1:0] addrw2
);

    dec_op_t            in_dec;
    dec_op_t            head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ALU_CNT-1:0] busy;
    logic [ALU_CNT-1:0] free;
    logic [ALU_CNT-1:0] grant;
    logic               issue;
    logic               lock_req;
    operand_t           opx;
    operand_t           opy;
    slot_t              new_slot;

    logic [ALU_CNT-1:0] en_q;      // also the pending mask: a slot issued last cycle is not yet busy in the RS
    slot_t              slot_q [ALU_CNT];
    tag_t               tag_ctr;
    logic               lock_en_q;
    regaddr_t           lock_addr_q;
    tag_t               lock_tag_q;

    assign in_dec   = {in_pc, in_op, in_rs1, in_rs2, in_rd};
    assign in_ready = !fifo_full;

    dispatch_fifo #(
        .WIDTH ($bits(dec_op_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (in_valid && in_ready),
        .pop   (issue),
        .din   (in_dec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rf_rx_addr = head.rs1;
    assign rf_ry_addr = head.rs2;

    assign busy     = {alu2_next_busy, alu1_next_busy, alu0_next_busy};
    assign free     = ~busy & ~en_q;
    assign grant    = pick_lowest(free);
    assign issue    = !fifo_empty && (|free) && !flush;
    assign lock_req = issue && (head.rd != '0);

    assign opx = resolve_operand(head.rs1, rf_tagx, rf_datax, cdb_en, cdb_tag, cdb_data);
    assign opy = resolve_operand(head.rs2, rf_tagy, rf_datay, cdb_en, cdb_tag, cdb_data);

    // Assemble the payload for whichever slot is granted this cycle.
    // NOTE: every field gets a value on every path, so no latch can be inferred.
    always_comb begin
        new_slot       = '0;
        new_slot.pc    = head.pc;
        new_slot.op    = head.op;
        new_slot.tagx  = opx.tag;
        new_slot.datax = opx.data;
        new_slot.tagy  = opy.tag;
        new_slot.datay = opy.data;
        new_slot.addrw = head.rd;
        new_slot.tagw  = (head.rd != '0) ? tag_ctr : UNLOCKED;
    end

    // Registered issue pulses, held slot payloads, rename counter and RF lock pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q        <= '0;
            tag_ctr     <= tag_t'(1);
            lock_en_q   <= 1'b0;
            lock_addr_q <= '0;
            lock_tag_q  <= UNLOCKED;
            for (int k = 0; k < ALU_CNT; k++) slot_q[k] <= '0;
        end else begin
            en_q      <= issue ? grant : '0;
            lock_en_q <= lock_req;
            if (lock_req) begin
                lock_addr_q <= head.rd;
                lock_tag_q  <= tag_ctr;
                tag_ctr     <= next_tag(tag_ctr);
            end
            for (int k = 0; k < ALU_CNT; k++) begin
                if (issue && grant[k]) slot_q[k] <= new_slot;
            end
        end
    end

    assign rf_lock_en   = lock_en_q;
    assign rf_lock_addr = lock_addr_q;
    assign rf_lock_tag  = lock_tag_q;

    assign en0 = en_q[0];
    assign en1 = en_q[1];
    assign en2 = en_q[2];

    assign pc0    = slot_q[0].pc;
    assign pc1    = slot_q[1].pc;
    assign pc2    = slot_q[2].pc;
    assign op0    = slot_q[0].op;
    assign op1    = slot_q[1].op;
    assign op2    = slot_q[2].op;
    assign tagx0  = slot_q[0].tagx;
    assign tagx1  = slot_q[1].tagx;
    assign tagx2  = slot_q[2].tagx;
    assign tagy0  = slot_q[0].tagy;
    assign tagy1  = slot_q[1].tagy;
    assign tagy2  = slot_q[2].tagy;
    assign tagw0  = slot_q[0].tagw;
    assign tagw1  = slot_q[1].tagw;
    assign tagw2  = slot_q[2].tagw;
    assign datax0 = slot_q[0].datax;
    assign datax1 = slot_q[1].datax;
    assign datax2 = slot_q[2].datax;
    assign datay0 = slot_q[0].datay;
    assign datay1 = slot_q[1].datay;
    assign datay2 = slot_q[2].datay;
    assign addrw0 = slot_q[0].addrw;
    assign addrw1 = slot_q[1].addrw;
    assign addrw2 = slot_q[2].addrw;

endmodule

// File: tb/tb_rs_alu_dispatch.sv
// Self-checking bench for rs_alu_dispatch: a queue-based reference model
// predicts each issue; a monitor compares every cycle's registered outputs.
module tb_rs_alu_dispatch;
    import rs_alu_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush, in_valid, in_ready;
    logic [31:0] in_pc;
    logic [5:0]  in_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [4:0]  rf_rx_addr, rf_ry_addr;
    logic [3:0]  rf_tagx, rf_tagy;
    logic [31:0] rf_datax, rf_datay;
    logic        rf_lock_en;
    logic [4:0]  rf_lock_addr;
    logic [3:0]  rf_lock_tag;
    logic        cdb_en;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [2:0]  busy_in;
    logic [2:0]  en_v;
    logic [31:0] pc_a [3];
    logic [5:0]  op_a [3];
    logic [3:0]  tagx_a [3], tagy_a [3], tagw_a [3];
    logic [31:0] datax_a [3], datay_a [3];
    logic [4:0]  addrw_a [3];

    // Behavioural register file answering the DUT's read addresses.
    logic [3:0]  rf_tag_m [32];
    logic [31:0] rf_data_m [32];
    always_comb begin
        rf_tagx  = rf_tag_m[rf_rx_addr];
        rf_tagy  = rf_tag_m[rf_ry_addr];
        rf_datax = rf_data_m[rf_rx_addr];
        rf_datay = rf_data_m[rf_ry_addr];
    end

    rs_alu_dispatch dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .rf_rx_addr(rf_rx_addr), .rf_ry_addr(rf_ry_addr),
        .rf_tagx(rf_tagx), .rf_tagy(rf_tagy), .rf_datax(rf_datax), .rf_datay(rf_datay),
        .rf_lock_en(rf_lock_en), .rf_lock_addr(rf_lock_addr), .rf_lock_tag(rf_lock_tag),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu0_next_busy(busy_in[0]), .alu1_next_busy(busy_in[1]), .alu2_next_busy(busy_in[2]),
        .en0(en_v[0]), .en1(en_v[1]), .en2(en_v[2]),
        .pc0(pc_a[0]), .pc1(pc_a[1]), .pc2(pc_a[2]),
        .op0(op_a[0]), .op1(op_a[1]), .op2(op_a[2]),
        .tagx0(tagx_a[0]), .tagx1(tagx_a[1]), .tagx2(tagx_a[2]),
        .tagy0(tagy_a[0]), .tagy1(tagy_a[1]), .tagy2(tagy_a[2]),
        .tagw0(tagw_a[0]), .tagw1(tagw_a[1]), .tagw2(tagw_a[2]),
        .datax0(datax_a[0]), .datax1(datax_a[1]), .datax2(datax_a[2]),
        .datay0(datay_a[0]), .datay1(datay_a[1]), .datay2(datay_a[2]),
        .addrw0(addrw_a[0]), .addrw1(addrw_a[1]), .addrw2(addrw_a[2])
    );

    typedef struct {
        int          slot;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [3:0]  tagx, tagy, tagw;
        logic [31:0] datax, datay;
        logic [4:0]  addrw;
        logic        lock;
        logic [4:0]  lock_addr;
        logic [3:0]  lock_tag;
    } exp_t;

    exp_t    exp_q [$];
    dec_op_t model_q [$];
    exp_t    held [3];
    int      ctr = 1;
    int      prev_slot = -1;
    int      tests = 0;
    int      fails = 0;
    bit      mon_on = 1'b0;

    // Stimulus for the next cycle.
    bit          s_valid, s_flush, s_cen;
    dec_op_t     s_op;
    logic [2:0]  s_busy;
    logic [3:0]  s_ctag;
    logic [31:0] s_cdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.slot = -1; e.pc = '0; e.op = '0; e.tagx = '0; e.tagy = '0; e.tagw = '0;
        e.datax = '0; e.datay = '0; e.addrw = '0; e.lock = 1'b0; e.lock_addr = '0; e.lock_tag = '0;
        return e;
    endfunction

    // Operand rules: r0 always ready as 0; ready RF value; CDB catch; else wait on tag.
    task automatic ref_operand(input logic [4:0] idx, output logic [3:0] tag, output logic [31:0] data);
        tag  = '0;
        data = '0;
        if (idx != 0) begin
            if (rf_tag_m[idx] == 0)                         data = rf_data_m[idx];
            else if (s_cen && s_ctag == rf_tag_m[idx])      data = s_cdata;
            else                                            tag  = rf_tag_m[idx];
        end
    endtask

    function automatic dec_op_t rand_op();
        dec_op_t o;
        o.pc  = $urandom;
        o.op  = 6'($urandom);
        o.rs1 = 5'($urandom);
        o.rs2 = 5'($urandom);
        o.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        return o;
    endfunction

    // Apply stimulus, predict this cycle's issue, advance one clock (negedge to negedge).
    task automatic step();
        int      sz;
        int      k;
        bit      acc;
        dec_op_t h;
        exp_t    e;
        in_valid = s_valid; flush = s_flush; busy_in = s_busy;
        {in_pc, in_op, in_rs1, in_rs2, in_rd} = s_op;
        cdb_en = s_cen; cdb_tag = s_ctag; cdb_data = s_cdata;
        #1;
        sz  = model_q.size();
        acc = s_valid && (sz < FIFO_DEPTH);
        check("in_ready", 64'(in_ready), 64'(sz < FIFO_DEPTH));
        if (sz > 0) begin
            check("rf_rx_addr", 64'(rf_rx_addr), 64'(model_q[0].rs1));
            check("rf_ry_addr", 64'(rf_ry_addr), 64'(model_q[0].rs2));
        end
        k = -1;
        if (sz > 0 && !s_flush)
            for (int i = 2; i >= 0; i--)
                if (!s_busy[i] && prev_slot != i) k = i;
        if (k >= 0) begin
            h = model_q.pop_front();
            e = zero_exp();
            e.slot = k; e.pc = h.pc; e.op = h.op; e.addrw = h.rd;
            ref_operand(h.rs1, e.tagx, e.datax);
            ref_operand(h.rs2, e.tagy, e.datay);
            if (h.rd != 0) begin
                e.tagw = 4'(ctr); e.lock = 1'b1; e.lock_addr = h.rd; e.lock_tag = 4'(ctr);
                ctr = ctr % 15 + 1;
            end
            exp_q.push_back(e);
        end
        prev_slot = k;
        if (s_flush) model_q.delete();
        else if (acc) model_q.push_back(s_op);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_stim();
        s_valid = 0; s_flush = 0; s_cen = 0; s_busy = '0; s_ctag = '0; s_cdata = '0; s_op = '0;
    endtask

    // Monitor: after every edge, compare issue mask, lock pulse and all slot payloads.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                exp_t       e;
                logic [2:0] exp_en;
                e = zero_exp();
                exp_en = '0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_en[e.slot] = 1'b1;
                    held[e.slot] = e;
                end
                check("en_mask", 64'(en_v), 64'(exp_en));
                check("lock_en", 64'(rf_lock_en), 64'(e.lock));
                if (e.lock) begin
                    check("lock_addr", 64'(rf_lock_addr), 64'(e.lock_addr));
                    check("lock_tag", 64'(rf_lock_tag), 64'(e.lock_tag));
                end
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("pc%0d", k),    64'(pc_a[k]),    64'(held[k].pc));
                    check($sformatf("op%0d", k),    64'(op_a[k]),    64'(held[k].op));
                    check($sformatf("tagx%0d", k),  64'(tagx_a[k]),  64'(held[k].tagx));
                    check($sformatf("tagy%0d", k),  64'(tagy_a[k]),  64'(held[k].tagy));
                    check($sformatf("tagw%0d", k),  64'(tagw_a[k]),  64'(held[k].tagw));
                    check($sformatf("datax%0d", k), 64'(datax_a[k]), 64'(held[k].datax));
                    check($sformatf("datay%0d", k), 64'(datay_a[k]), 64'(held[k].datay));
                    check($sformatf("addrw%0d", k), 64'(addrw_a[k]), 64'(held[k].addrw));
                end
            end
        end
    end

    initial begin
        idle_stim();
        in_valid = 0; flush = 0; busy_in = '0; cdb_en = 0; cdb_tag = '0; cdb_data = '0;
        {in_pc, in_op, in_rs1, in_rs2, in_rd} = '0;
        for (int i = 0; i < 32; i++) begin
            rf_tag_m[i]  = '0;
            rf_data_m[i] = 32'(i * 16);
        end
        for (int k = 0; k < 3; k++) held[k] = zero_exp();

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_en", 64'(en_v), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_lock_en", 64'(rf_lock_en), 64'(0));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_tagw%0d", k), 64'(tagw_a[k]), 64'(0));
            check($sformatf("rst_pc%0d", k), 64'(pc_a[k]), 64'(0));
        end
        rst = 1'b0;
        mon_on = 1'b1;

        // First op: rd=3, rs1 ready with value 5.
        rf_tag_m[2] = 4'd0; rf_data_m[2] = 32'd5;
        s_op = '{pc: 32'h100, op: OP_ADD, rs1: 5'd2, rs2: 5'd0, rd: 5'd3};
        s_valid = 1; step();
        s_valid = 0; step();
        check("dir_en0", 64'(en_v), 64'(3'b001));
        check("dir_datax0", 64'(datax_a[0]), 64'(5));
        check("dir_tagx0", 64'(tagx_a[0]), 64'(0));
        check("dir_tagw0", 64'(tagw_a[0]), 64'(1));
        check("dir_lock", 64'({rf_lock_en, rf_lock_addr, rf_lock_tag}), 64'({1'b1, 5'd3, 4'd1}));

        // Slot 0 busy: next op goes to slot 1.
        s_op = rand_op(); s_busy = 3'b001;
        s_valid = 1; step();
        s_valid = 0; step();
        check("dir_en1", 64'(en_v), 64'(3'b010));

        // All slots busy: fill the FIFO, then stall.
        s_busy = 3'b111;
        for (int i = 0; i < 4; i++) begin s_op = rand_op(); s_valid = 1; step(); end
        check("full_in_ready", 64'(in_ready), 64'(0));
        s_valid = 0;
        repeat (3) step();
        s_busy = 3'b000;
        for (int i = 0; i < 20 && model_q.size() > 0; i++) step();
        repeat (2) step();

        // CDB bypass of rs1 waiting on tag 7.
        rf_tag_m[5] = 4'd7; rf_data_m[5] = 32'h1234;
        s_op = '{pc: 32'h200, op: OP_SUB, rs1: 5'd5, rs2: 5'd0, rd: 5'd0};
        s_valid = 1; step();
        s_valid = 0; s_cen = 1; s_ctag = 4'd7; s_cdata = 32'hAB; step();
        s_cen = 0;
        check("byp_en0", 64'(en_v), 64'(3'b001));
        check("byp_tagx0", 64'(tagx_a[0]), 64'(0));
        check("byp_datax0", 64'(datax_a[0]), 64'(32'hAB));
        check("byp_rd0_nolock", 64'(rf_lock_en), 64'(0));

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            if (c % 8 == 0) begin
                int r;
                r = $urandom_range(0, 31);
                rf_tag_m[r]  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                rf_data_m[r] = $urandom;
            end
            s_valid = ($urandom_range(0, 3) != 0);
            s_op    = rand_op();
            s_busy  = 3'($urandom);
            s_flush = ($urandom_range(0, 24) == 0);
            s_cen   = $urandom_range(0, 1) == 1;
            s_ctag  = (model_q.size() > 0 && $urandom_range(0, 1) == 1) ? rf_tag_m[model_q[0].rs1]
                                                                         : 4'($urandom);
            s_cdata = $urandom;
            step();
        end
        idle_stim();
        repeat (3) step();

        // Flush with three buffered ops.
        s_busy = 3'b111;
        for (int i = 0; i < 3; i++) begin s_op = rand_op(); s_valid = 1; step(); end
        s_flush = 1; s_op = rand_op(); step();
        s_flush = 0; s_valid = 0;
        check("flush_in_ready", 64'(in_ready), 64'(1));
        s_busy = 3'b000;
        repeat (2) step();

        // Asynchronous reset while an issue pulse is on the outputs.
        s_op = '{pc: 32'h300, op: OP_OR, rs1: 5'd1, rs2: 5'd2, rd: 5'd4};
        s_valid = 1; step();
        s_valid = 0; step();
        mon_on = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_en", 64'(en_v), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_lock_en", 64'(rf_lock_en), 64'(0));
        for (int k = 0; k < 3; k++) check($sformatf("arst_pc%0d", k), 64'(pc_a[k]), 64'(0));
        model_q.delete(); exp_q.delete();
        ctr = 1; prev_slot = -1;
        for (int k = 0; k < 3; k++) held[k] = zero_exp();
        @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;

        // Counter restarts at 1 after reset.
        s_op = '{pc: 32'h400, op: OP_XOR, rs1: 5'd0, rs2: 5'd0, rd: 5'd7};
        s_valid = 1; step();
        s_valid = 0; step();
        check("post_rst_tagw0", 64'(tagw_a[0]), 64'(1));
        repeat (3) step();

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
